fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding scoreboard for the rv32i pipeline; generalises the single-producer opcode-based main/sub data select to a tracked window of in-flight producers.
- Keeps a shift register of producer records (rd, opcode) for stages EX..WB and resolves every source-register read port against them, youngest first.
- Signals a load-use stall when the youngest matching producer's result is not yet available.
- Sits between ID (rs lookup) and the EX/MEM/WB stage data buses.

Parameters:
- XLEN, 32, datapath width
- DEPTH, 3, tracked stages; index 0 = EX, DEPTH-1 = WB
- NUM_RS, 2, number of source read ports
- LOAD_READY_STAGE, 1, first stage index at which load data on stage_sub_data is valid; range 0..DEPTH-1
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  global freeze, e.g. memory wait; no entry moves
- flush  in  1  kill issuing instruction and entries 0..DEPTH-2
- issue_valid  in  1  ID instruction enters EX this cycle
- issue_rd  in  5  its destination register
- issue_opcode  in  7  its opcode
- stage_main_data  in  DEPTH*XLEN  ALU result per stage; slice k = stage k
- stage_sub_data  in  DEPTH*XLEN  pc+4 or load data per stage
- rs_addr  in  NUM_RS*5  source registers being read in ID
- fwd_hit  out  NUM_RS  forwarding value selected for the port
- fwd_data  out  NUM_RS*XLEN  forwarded value; 0 when no hit
- need_stall  out  1  load-use hazard; ID must hold and EX gets a bubble
- stall_cycles  out  CNT_W  saturating count of cycles with need_stall=1

Behaviour:
- Entry k holds {valid, wb, rd, opcode}.
- wb decode:
  - 0110111, 0010111, 0010011, 0110011 -> wb=1, data = main
  - 1101111, 1100111, 0000011 -> wb=1, data = sub
  - All other opcodes, e.g. branch 1100011 and store 0100011 -> wb=0, never forwarded.
- Entry k is ready when it is not a load (0000011), or when k >= LOAD_READY_STAGE.
- Each rising edge, priority in this order:
  - rst: all entries invalid; stall_cycles=0.
  - hold: all state frozen, including stall_cycles.
  - Otherwise shift: entry k+1 <= entry k, and entry DEPTH-1 retires.
- New entry 0 at shift:
  - It is a bubble (valid=0) if flush, need_stall or !issue_valid.
  - Otherwise it is {1, wb(issue_opcode), issue_rd, issue_opcode}.
- flush additionally invalidates entries 1..DEPTH-1 after the shift, i.e. the old entries 0..DEPTH-2. The old entry DEPTH-1 retires normally.
- Lookup per port p is combinational from registered entries and stage data; it has zero latency:
  - Candidates are entries with valid & wb & rd==rs_addr[p] & rs_addr[p]!=0.
  - The lowest index (youngest) candidate wins; older candidates are ignored.
  - Winner ready: fwd_hit[p]=1, fwd_data[p] = main or sub slice of that stage.
  - Winner not ready: fwd_hit[p]=0, fwd_data[p]=0, stall request for port p.
  - No candidate: hit 0, data 0; the register file value is used.
- need_stall = OR of the port stall requests. It is not gated by hold.
- stall_cycles increments on each non-held edge with need_stall=1 and saturates at all-ones.
- Reset values: fwd_hit=0, fwd_data=0, need_stall=0, stall_cycles=0. All entries are invalid, so outputs settle to these values immediately after reset.
- Reset mid-operation discards all in-flight entries; no forwarding occurs in the following cycle.
- rd=0 producers are tracked but never match.
- Two ports may hit the same entry.

Test Plan:
- Reset, then issue ADDI (0010011) rd=3. Next cycle rs_addr[0]=3, stage_main_data[0]=1, stage_sub_data[0]=2 -> fwd_hit[0]=1, fwd_data[0]=1, need_stall=0.
- Issue JAL (1101111) rd=1 then ADD rd=5. Read rs=1 with entry at stage 1, main=1, sub=2 -> fwd_data=2. Then issue BEQ and SB with rd field 7, read rs=7 -> fwd_hit=0, fwd_data=0.
- Issue LB (0000011) rd=4, then read rs=4 while it sits in stage 0 -> need_stall=1 and stall_cycles goes 0->1. Next cycle a bubble is in EX and the load is in stage 1, sub=0xDEAD_BEEF -> fwd_hit=1, fwd_data=0xDEADBEEF, need_stall=0.
- Issue ADDI rd=6 (main 0x10), then ADDI rd=6 (main 0x20). Read rs=6 with both in flight -> youngest wins, fwd_data=0x20. Read rs=0 with an rd=0 producer in flight -> no hit.
- With 3 valid entries, assert flush -> only the old stage-2 entry retires and all matches drop to 0. Assert hold for 3 cycles with a pending load stall -> entries unchanged and stall_cycles unchanged.
- CNT_W=2: sustain need_stall for 5 cycles -> stall_cycles saturates at 3. Then rst for 1 cycle -> all outputs 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers from EX to WB and
// resolves each ID source-register read against them, youngest first.
// A load whose data is not yet on its stage's sub bus raises a stall.
module fwd_scoreboard #(
   parameter int XLEN             = 32,
   parameter int DEPTH            = 3,
   parameter int NUM_RS           = 2,
   parameter int LOAD_READY_STAGE = 1,
   parameter int CNT_W            = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hold,
   input  logic                    flush,
   input  logic                    issue_valid,
   input  logic [4:0]              issue_rd,
   input  logic [6:0]              issue_opcode,
   input  logic [DEPTH*XLEN-1:0]   stage_main_data,
   input  logic [DEPTH*XLEN-1:0]   stage_sub_data,
   input  logic [NUM_RS*5-1:0]     rs_addr,
   output logic [NUM_RS-1:0]       fwd_hit,
   output logic [NUM_RS*XLEN-1:0]  fwd_data,
   output logic                    need_stall,
   output logic [CNT_W-1:0]        stall_cycles
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_OPIMM = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   // Opcodes that write rd; everything else (branches, stores, ...) never forwards.
   function automatic logic op_writes(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_JAL, OP_JALR, OP_LOAD: op_writes = 1'b1;
         default: op_writes = 1'b0;
      endcase
   endfunction

   // Jumps deliver pc+4 and loads deliver memory data on the sub bus.
   function automatic logic op_uses_sub(input logic [6:0] op);
      case (op)
         OP_JAL, OP_JALR, OP_LOAD: op_uses_sub = 1'b1;
         default: op_uses_sub = 1'b0;
      endcase
   endfunction

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] wb_q, wb_d;
   logic [4:0]       rd_q [DEPTH];
   logic [4:0]       rd_d [DEPTH];
   logic [6:0]       op_q [DEPTH];
   logic [6:0]       op_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DEPTH-1:0]  ready_c;
   logic [XLEN-1:0]   entry_data_c [DEPTH];
   logic [NUM_RS-1:0] stall_req_c;
   logic              found_c;

   // Per-entry result readiness and data bus selection.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic LATE_STAGE = (gi >= LOAD_READY_STAGE);
         assign ready_c[gi]      = (op_q[gi] != OP_LOAD) || LATE_STAGE;
         assign entry_data_c[gi] = op_uses_sub(op_q[gi]) ? stage_sub_data[gi*XLEN +: XLEN]
                                                         : stage_main_data[gi*XLEN +: XLEN];
      end
   endgenerate

   // Zero-latency lookup: the first (youngest) matching entry decides hit, data or stall.
   always_comb begin
      fwd_hit     = '0;
      fwd_data    = '0;
      stall_req_c = '0;
      found_c     = 1'b0;
      for (int p = 0; p < NUM_RS; p++) begin
         found_c = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (!found_c && valid_q[k] && wb_q[k] &&
                rs_addr[p*5 +: 5] != 5'd0 && rd_q[k] == rs_addr[p*5 +: 5]) begin
               found_c = 1'b1;
               if (ready_c[k]) begin
                  fwd_hit[p]                 = 1'b1;
                  fwd_data[p*XLEN +: XLEN]   = entry_data_c[k];
               end else begin
                  stall_req_c[p] = 1'b1;
               end
            end
         end
      end
   end

   assign need_stall   = |stall_req_c;
   assign stall_cycles = cnt_q;

   // Shift the producer window one stage unless frozen; insert the issuing
   // instruction or a bubble, and kill younger entries on flush.
   always_comb begin
      valid_d = valid_q;
      wb_d    = wb_q;
      rd_d    = rd_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      if (!hold) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            valid_d[k] = valid_q[k-1] & ~flush;
            wb_d[k]    = wb_q[k-1];
            rd_d[k]    = rd_q[k-1];
            op_d[k]    = op_q[k-1];
         end
         valid_d[0] = issue_valid & ~flush & ~need_stall;
         wb_d[0]    = op_writes(issue_opcode);
         rd_d[0]    = issue_rd;
         op_d[0]    = issue_opcode;
         if (need_stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; rd/opcode need no reset because valid gates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         wb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         wb_q    <= wb_d;
         rd_q    <= rd_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fwd_scoreboard;
   localparam int XLEN  = 32;
   localparam int DEPTH = 3;
   localparam int NRS   = 2;
   localparam int LRS   = 1;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic rst, hold, flush, issue_valid;
   logic [4:0] issue_rd;
   logic [6:0] issue_opcode;
   logic [DEPTH*XLEN-1:0] main_d, sub_d;
   logic [NRS*5-1:0] rs_addr;
   logic [NRS-1:0] fwd_hit;
   logic [NRS*XLEN-1:0] fwd_data;
   logic need_stall;
   logic [CNT_W-1:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int cyc      = 0;

   fwd_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RS(NRS),
                    .LOAD_READY_STAGE(LRS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_opcode(issue_opcode),
      .stage_main_data(main_d), .stage_sub_data(sub_d), .rs_addr(rs_addr),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .need_stall(need_stall),
      .stall_cycles(stall_cycles));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct { bit v; bit [4:0] rd; bit [6:0] op; } rec_t;
   rec_t mp [DEPTH];
   int unsigned m_cnt = 0;

   // 0: no writeback, 1: ALU result, 2: pc+4 / jump, 3: load (sub, late)
   function automatic int op_kind(input bit [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return 1;
         7'b1101111, 7'b1100111: return 2;
         7'b0000011: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic model_out(output logic [NRS-1:0] h, output logic [NRS*XLEN-1:0] d,
                            output logic st);
      logic [4:0] r;
      int kd;
      h = '0; d = '0; st = 1'b0;
      for (int p = 0; p < NRS; p++) begin
         r = rs_addr[p*5 +: 5];
         if (r == 5'd0) continue;
         for (int k = 0; k < DEPTH; k++) begin
            kd = op_kind(mp[k].op);
            if (mp[k].v && kd != 0 && mp[k].rd == r) begin
               if (kd == 3 && k < LRS) st = 1'b1;
               else begin
                  h[p] = 1'b1;
                  d[p*XLEN +: XLEN] = (kd == 1) ? main_d[k*XLEN +: XLEN] : sub_d[k*XLEN +: XLEN];
               end
               break;
            end
         end
      end
   endtask

   initial for (int k = 0; k < DEPTH; k++) mp[k] = '{1'b0, 5'd0, 7'd0};

   // Model state advance on each rising edge, using inputs held stable across it.
   always @(posedge clk) begin : model_upd
      logic [NRS-1:0] eh;
      logic [NRS*XLEN-1:0] ed;
      logic est;
      model_out(eh, ed, est);
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mp[k].v = 1'b0;
         m_cnt = 0;
      end else if (!hold) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            mp[k] = mp[k-1];
            if (flush) mp[k].v = 1'b0;
         end
         mp[0].v  = issue_valid && !flush && !est;
         mp[0].rd = issue_rd;
         mp[0].op = issue_opcode;
         if (est && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare of every output against the model, one line per cycle.
   always @(negedge clk) begin : compare
      logic [NRS-1:0] eh;
      logic [NRS*XLEN-1:0] ed;
      logic est;
      cyc++;
      if (chk_en) begin
         model_out(eh, ed, est);
         check("model_hit",   64'(fwd_hit), 64'(eh));
         check("model_data",  64'(fwd_data), 64'(ed));
         check("model_stall", 64'(need_stall), 64'(est));
         check("model_cnt",   64'(stall_cycles), 64'(m_cnt));
         $display("cyc %0d rs=%h hit=%b data=%h stall=%b cnt=%0d", cyc, rs_addr,
                  fwd_hit, fwd_data, need_stall, stall_cycles);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [6:0] op);
      issue_valid = 1'b1; issue_rd = rd; issue_opcode = op;
      step();
      issue_valid = 1'b0;
   endtask

   task automatic set_main(input int k, input logic [XLEN-1:0] v);
      main_d[k*XLEN +: XLEN] = v;
   endtask

   task automatic set_sub(input int k, input logic [XLEN-1:0] v);
      sub_d[k*XLEN +: XLEN] = v;
   endtask

   localparam logic [6:0] ADDI = 7'b0010011, ADD = 7'b0110011, JAL = 7'b1101111;
   localparam logic [6:0] BEQ  = 7'b1100011, SB  = 7'b0100011, LB  = 7'b0000011;

   bit [6:0] op_tab [10];

   initial begin
      op_tab = '{7'b0110111, 7'b0010111, ADDI, ADD, JAL, 7'b1100111, LB, LB, BEQ, SB};
      rst = 1'b1; hold = 1'b0; flush = 1'b0; issue_valid = 1'b0;
      issue_rd = '0; issue_opcode = '0; main_d = '0; sub_d = '0; rs_addr = '0;
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_hit", 64'(fwd_hit), 64'd0);
      check("reset_data", 64'(fwd_data), 64'd0);
      check("reset_stall", 64'(need_stall), 64'd0);
      check("reset_cnt", 64'(stall_cycles), 64'd0);

      // ADDI rd=3 forwarded from EX main bus
      issue(5'd3, ADDI);
      rs_addr[4:0] = 5'd3; set_main(0, 32'd1); set_sub(0, 32'd2);
      @(negedge clk);
      check("addi_hit", 64'(fwd_hit[0]), 64'd1);
      check("addi_data", 64'(fwd_data[XLEN-1:0]), 64'd1);
      check("addi_stall", 64'(need_stall), 64'd0);

      // JAL in stage 1 forwards pc+4 from sub bus
      issue(5'd1, JAL);
      issue(5'd5, ADD);
      rs_addr[4:0] = 5'd1; set_main(1, 32'd1); set_sub(1, 32'd2);
      @(negedge clk);
      check("jal_data", 64'(fwd_data[XLEN-1:0]), 64'd2);

      // branch / store never write back
      issue(5'd7, BEQ);
      issue(5'd7, SB);
      rs_addr[4:0] = 5'd7;
      @(negedge clk);
      check("nowb_hit", 64'(fwd_hit[0]), 64'd0);
      check("nowb_data", 64'(fwd_data[XLEN-1:0]), 64'd0);

      // load-use stall, then forward from stage 1
      rs_addr[4:0] = 5'd0;
      issue(5'd4, LB);
      rs_addr[4:0] = 5'd4;
      @(negedge clk);
      check("lu_stall", 64'(need_stall), 64'd1);
      check("lu_cnt0", 64'(stall_cycles), 64'd0);
      step();
      set_sub(1, 32'hDEAD_BEEF);
      @(negedge clk);
      check("lu_hit", 64'(fwd_hit[0]), 64'd1);
      check("lu_data", 64'(fwd_data[XLEN-1:0]), 64'hDEAD_BEEF);
      check("lu_stall_clr", 64'(need_stall), 64'd0);
      check("lu_cnt1", 64'(stall_cycles), 64'd1);

      // youngest wins; both ports on the same entry; rd=0 never matches
      rs_addr = '0;
      issue(5'd6, ADDI);
      issue(5'd6, ADDI);
      set_main(0, 32'h20); set_main(1, 32'h10);
      rs_addr = {5'd6, 5'd6};
      @(negedge clk);
      check("young_data0", 64'(fwd_data[XLEN-1:0]), 64'h20);
      check("young_data1", 64'(fwd_data[2*XLEN-1:XLEN]), 64'h20);
      rs_addr = '0;
      issue(5'd0, ADDI);
      @(negedge clk);
      check("rd0_hit", 64'(fwd_hit), 64'd0);

      // flush: all matches drop
      issue(5'd8, ADDI); issue(5'd9, ADDI); issue(5'd10, ADDI);
      rs_addr = {5'd9, 5'd8};
      @(negedge clk);
      check("preflush_hit", 64'(fwd_hit), 64'd3);
      flush = 1'b1; step(); flush = 1'b0;
      @(negedge clk);
      check("flush_hit", 64'(fwd_hit), 64'd0);

      // hold with pending load stall
      rs_addr = '0;
      issue(5'd11, LB);
      rs_addr[4:0] = 5'd11; hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         check("hold_stall", 64'(need_stall), 64'd1);
         check("hold_cnt", 64'(stall_cycles), 64'd1);
      end
      hold = 1'b0; set_sub(1, 32'h1234);
      step();
      @(negedge clk);
      check("unhold_data", 64'(fwd_data[XLEN-1:0]), 64'h1234);
      check("unhold_cnt", 64'(stall_cycles), 64'd2);

      // saturation of the 2-bit counter
      rs_addr[4:0] = 5'd12;
      for (int i = 0; i < 3; i++) begin
         issue(5'd12, LB);
         @(negedge clk);
         check("sat_stall", 64'(need_stall), 64'd1);
         step();
      end
      @(negedge clk);
      check("sat_cnt", 64'(stall_cycles), 64'd3);
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      check("rst_hit", 64'(fwd_hit), 64'd0);
      check("rst_data", 64'(fwd_data), 64'd0);
      check("rst_stall", 64'(need_stall), 64'd0);
      check("rst_cnt", 64'(stall_cycles), 64'd0);

      // randomized traffic checked by the model every cycle
      for (int n = 0; n < 1500; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         hold         = ($urandom_range(0, 9) == 0);
         flush        = ($urandom_range(0, 19) == 0);
         issue_valid  = ($urandom_range(0, 9) < 7);
         issue_rd     = 5'($urandom_range(0, 7));
         issue_opcode = op_tab[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) == 0) issue_opcode = 7'($urandom());
         for (int p = 0; p < NRS; p++) rs_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
         for (int k = 0; k < DEPTH; k++) begin
            set_main(k, $urandom());
            set_sub(k, $urandom());
         end
         step();
      end
      rst = 1'b0; hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
